// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: CPU memory bus and uart core bus used by uart_tx_buffer.
interface mem_bus_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, input mem_rdata, mem_ready);
    modport slave (input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, output mem_rdata, mem_ready);
endinterface

interface uart_core_if;
    logic        uart_valid;
    logic        uart_instr;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    modport master (output uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb, input uart_rdata, uart_ready);
    modport slave (input uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb, output uart_rdata, uart_ready);
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: TX FIFO and request serialiser in front of a uart core.
// Optional status register at STATUS_OFF is built when UART_FIFO_STATUS_EN is defined.
module uart_tx_buffer #(
    parameter int DEPTH      = 16,
    parameter int STATUS_OFF = 4
) (
    input logic         clock,
    input logic         reset,
    mem_bus_if.slave    mem,
    uart_core_if.master uart
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, TX, RX} state_t;
    state_t state, state_n;
    logic [7:0] fifo [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic pend_valid, pend_write;
    logic [7:0] pend_data, push_data;
    logic new_req, is_write, is_stat, full, empty, busy, pop, push, wr_now, rx_done;
    logic unused_bits;
    assign unused_bits = ^{mem.mem_instr, mem.mem_addr, mem.mem_wdata[31:8], uart.uart_rdata[31:8]};
`ifdef UART_FIFO_STATUS_EN
    assign is_stat = mem.mem_addr[7:0] == 8'(STATUS_OFF);
`else
    assign is_stat = 1'b0;
`endif
    always_comb begin
        new_req = mem.mem_valid & ~pend_valid;
        is_write = |mem.mem_wstrb;
        full = count == (AW+1)'(DEPTH);
        empty = count == '0;
        busy = state != IDLE;
        pop = state == TX & uart.uart_ready;
        rx_done = state == RX & uart.uart_ready;
        wr_now = new_req & is_write & ~is_stat;
        // a pop frees the slot in the same edge, so a full FIFO can still accept
        push = (wr_now | pend_valid & pend_write) & (~full | pop);
        push_data = pend_valid ? pend_data : mem.mem_wdata[7:0];
        state_n = state == IDLE ? (!empty ? TX : (pend_valid & ~pend_write) ? RX : IDLE)
                                : (uart.uart_ready ? IDLE : state);
        uart.uart_valid = busy & ~uart.uart_ready;
        uart.uart_instr = 1'b0;
        uart.uart_addr = '0;
        uart.uart_wstrb = state == TX ? 4'hF : 4'h0;
        uart.uart_wdata = {24'h0, state == TX ? fifo[rd_ptr] : 8'h0};
    end
    always_ff @(posedge clock) begin
        if (push)
            fifo[wr_ptr] <= push_data;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_data <= '0;
            mem.mem_ready <= 1'b0;
            mem.mem_rdata <= '0;
        end else begin
            state <= state_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            mem.mem_ready <= push | rx_done | new_req & is_stat;
            if (rx_done)
                mem.mem_rdata <= {24'h0, uart.uart_rdata[7:0]};
`ifdef UART_FIFO_STATUS_EN
            else if (new_req & is_stat & ~is_write)
                mem.mem_rdata <= {16'h0, 8'(count), 5'h0, busy, full, empty};
`endif
            if (new_req & ~(push | is_stat)) begin
                pend_valid <= 1'b1;
                pend_write <= is_write;
                pend_data <= mem.mem_wdata[7:0];
            end else if (push | rx_done)
                pend_valid <= 1'b0;
        end
    end
endmodule
